uart_tx_feeder: RTL and testbench

//  Byte FIFO and pacing stage directly upstream of the UART transmitter.
//  - Accepts bytes from the host logic through a valid/ready write port.
//  - Launches each byte into the transmitter with a one-cycle o_Tx_DV pulse.
//  - Paces launches from the transmitter's active/done status.
//  - Host never needs to track the serial bit timing.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_byte_fifo.sv | 56 +++++
 rtl/uart_tx_feeder.sv | 100 ++++++++++
 tb/tb_uart_tx_feeder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
// Optional CR/LF expansion is enabled by defining UART_TX_CRLF_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACTIVE = 2'd1,
    S_WAIT_DONE   = 2'd2
  } feeder_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with extra-MSB pointers and registered-free head read.
// Head entry is readable combinationally whenever the FIFO is not empty.
module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Push,
  input  logic [7:0]            i_Data,
  input  logic                  i_Pop,
  output logic [7:0]            o_Head,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_q, wr_d;
  logic [DEPTH_LOG2:0] rd_q, rd_d;
  logic                push_ok;
  logic                pop_ok;

  assign o_Empty = (wr_q == rd_q);
  assign o_Full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                   (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
  assign o_Count = wr_q - rd_q;
  assign o_Head  = mem_q[rd_q[DEPTH_LOG2-1:0]];

  // Full is checked before any same-cycle pop, so a full FIFO never accepts.
  assign push_ok = i_Push && !o_Full;
  assign pop_ok  = i_Pop && !o_Empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push_ok) mem_q[wr_q[DEPTH_LOG2-1:0]] <= i_Data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch pacing in front of the UART transmitter.
// Define UART_TX_CRLF_EN to expand each LF into a CR/LF pair.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Wr_DV,
  input  logic [7:0]            i_Wr_Byte,
  output logic                  o_Wr_Ready,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Overflow,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Active,
  input  logic                  i_Tx_Done
);

  feeder_state_t state_q;
  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic          launch;
  logic          send_cr;
  logic          pop;

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Wr_DV),
    .i_Data  (i_Wr_Byte),
    .i_Pop   (pop),
    .o_Head  (head),
    .o_Full  (full),
    .o_Empty (empty),
    .o_Count (o_Count)
  );

  assign o_Wr_Ready = !full;

  // Both status lines low means the transmitter is truly back in idle.
  assign launch = (state_q == S_IDLE) && !empty &&
                  !i_Tx_Active && !i_Tx_Done;

`ifdef UART_TX_CRLF_EN
  logic cr_sent_q;
  assign send_cr = (head == ASCII_LF) && !cr_sent_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cr_sent_q <= 1'b0;
    end else if (launch) begin
      cr_sent_q <= send_cr;
    end
  end
`else
  assign send_cr = 1'b0;
`endif

  assign pop = launch && !send_cr;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_DV && full) begin
      o_Overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= send_cr ? ASCII_CR : head;
            state_q   <= S_WAIT_ACTIVE;
          end
        end
        S_WAIT_ACTIVE: begin
          if (i_Tx_Active) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder against a behavioural transmitter
// (4 clocks per bit, 10-bit frame, done high for 2 cycles).
module tb_uart_tx_feeder;

  localparam int DL    = 4;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_dv = 1'b0;
  logic [7:0]    wr_byte = 8'h00;
  logic          wr_ready;
  logic [DL:0]   count;
  logic          overflow;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          hold = 1'b0;
  logic          m_active = 1'b0;
  logic          m_done = 1'b0;
  int            m_state = 0;
  int            m_cnt = 0;
  int            coll = 0;
  logic [7:0]    captured [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH_LOG2(DL)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Wr_DV     (wr_dv),
    .i_Wr_Byte   (wr_byte),
    .o_Wr_Ready  (wr_ready),
    .o_Count     (count),
    .o_Overflow  (overflow),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (m_active | hold),
    .i_Tx_Done   (m_done)
  );

  // Transmitter model: captures the launched byte, counts launches while busy.
  always @(posedge clk) begin
    if (m_state == 0) begin
      if (tx_dv) begin
        captured.push_back(tx_byte);
        m_active <= 1'b1;
        m_cnt    <= 0;
        m_state  <= 1;
      end
    end else if (m_state == 1) begin
      if (tx_dv) coll <= coll + 1;
      if (m_cnt == FRAME - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_cnt    <= 0;
        m_state  <= 2;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      if (tx_dv) coll <= coll + 1;
      if (m_cnt == 1) begin
        m_done  <= 1'b0;
        m_state <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write(input logic [7:0] b);
    @(negedge clk);
    wr_dv   = 1'b1;
    wr_byte = b;
    @(negedge clk);
    wr_dv   = 1'b0;
  endtask

  task automatic wait_drain(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (captured.size() >= n && m_state == 0 && count == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++;
    if ({wr_ready, count, overflow, tx_dv, tx_byte} !==
        {1'b1, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset: rdy=%b cnt=%0d ovf=%b dv=%b byte=%h want 1 0 0 0 00",
               wr_ready, count, overflow, tx_dv, tx_byte);
    end
  endtask

  task automatic test_single();
    bit ok;
    captured.delete();
    @(negedge clk);
    wr_dv = 1'b1; wr_byte = 8'h55;
    @(posedge clk); #1;
    wr_dv = 1'b0;
    checks++;
    if (tx_dv !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_c1: dv=%b cnt=%0d want 0 1", tx_dv, count);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h55 || count !== 5'd0) begin
      errors++;
      $display("FAIL single_c2: dv=%b byte=%h cnt=%0d want 1 55 0",
               tx_dv, tx_byte, count);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_dv !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: dv=%b want 0", tx_dv);
    end
    wait_drain(1, ok);
    checks++;
    if (!ok || captured.size() != 1 || captured[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_data: n=%0d first=%h want 1 55",
               captured.size(), captured.size() > 0 ? captured[0] : 8'hxx);
    end
  endtask

  task automatic test_burst_fill();
    captured.delete();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(i));
    #1;
    checks++;
    if (wr_ready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL burst_full: rdy=%b cnt=%0d want 0 16", wr_ready, count);
    end
  endtask

  task automatic test_overflow();
    write(8'hEE);
    #1;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow: ovf=%b cnt=%0d want 1 16", overflow, count);
    end
  endtask

  task automatic test_drain();
    bit ok;
    hold = 1'b0;
    wait_drain(16, ok);
    checks++;
    if (!ok || captured.size() != 16) begin
      errors++;
      $display("FAIL drain_len: n=%0d want 16", captured.size());
    end
    for (int i = 0; i < 16 && i < captured.size(); i++) begin
      checks++;
      if (captured[i] !== 8'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got %h want %h", i, captured[i], 8'(i));
      end
    end
    checks++;
    if (overflow !== 1'b1 || coll != 0) begin
      errors++;
      $display("FAIL sticky: ovf=%b coll=%0d want 1 0", overflow, coll);
    end
  endtask

  task automatic test_full_pop_write();
    bit ok;
    do_reset();
    captured.delete();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) write(8'h80 + 8'(i));
    @(negedge clk);
    hold = 1'b0; wr_dv = 1'b1; wr_byte = 8'h77;
    @(posedge clk); #1;
    checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || tx_dv !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_write: cnt=%0d ovf=%b dv=%b want 15 1 1",
               count, overflow, tx_dv);
    end
    @(negedge clk);
    wr_dv = 1'b0;
    wait_drain(16, ok);
    checks++;
    if (!ok || captured.size() != 16 || captured[15] !== 8'h8F) begin
      errors++;
      $display("FAIL full_pop_drain: n=%0d last=%h want 16 8f", captured.size(),
               captured.size() > 0 ? captured[captured.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    captured.delete();
    write(8'h33);
    for (int i = 0; i < 50 && !m_active; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    do_reset();
    #1;
    checks++;
    if (m_active !== 1'b1 || count !== 5'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: act=%b cnt=%0d rdy=%b want 1 0 1",
               m_active, count, wr_ready);
    end
    write(8'hA5);
    @(posedge clk); #1;
    checks++;
    if (tx_dv !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL midframe_hold: dv=%b cnt=%0d want 0 1", tx_dv, count);
    end
    wait_drain(2, ok);
    checks++;
    if (!ok || captured.size() != 2 || captured[1] !== 8'hA5 || coll != 0) begin
      errors++;
      $display("FAIL midframe_data: n=%0d coll=%0d want 2 bytes 33 a5, 0 coll",
               captured.size(), coll);
    end
  endtask

  task automatic test_crlf();
    bit ok;
    logic [7:0] exp [$];
`ifdef UART_TX_CRLF_EN
    exp = '{8'h41, 8'h0D, 8'h0A};
`else
    exp = '{8'h41, 8'h0A};
`endif
    captured.delete();
    write(8'h41);
    write(8'h0A);
    wait_drain(exp.size(), ok);
    checks++;
    if (!ok || captured.size() != exp.size()) begin
      errors++;
      $display("FAIL crlf_len: n=%0d want %0d", captured.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < captured.size(); i++) begin
      checks++;
      if (captured[i] !== exp[i]) begin
        errors++;
        $display("FAIL crlf[%0d]: got %h want %h", i, captured[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_fill();
    test_overflow();
    test_drain();
    test_full_pop_write();
    test_reset_midframe();
    test_crlf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
